// File: rtl/flappy_pkg.sv
// Shared Flappy Bird definitions: game state encoding and screen/bird widths.
package flappy_pkg;

  localparam int unsigned Y_W      = 10;   // bird_y width (pixel rows)
  localparam int unsigned V_W      = 6;    // signed velocity width
  localparam int unsigned SCREEN_H = 480;  // visible rows

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DEAD
  } game_state_t;

endpackage

// File: rtl/bird_physics_if.sv
// Control/status bundle between the game top and the bird physics engine.
interface bird_physics_if;
  import flappy_pkg::*;

  logic                  ena;
  logic                  frame_tick;
  logic                  flap_btn;
  logic                  restart;
  logic                  collide;
  logic [Y_W-1:0]        bird_y;
  logic signed [V_W-1:0] bird_vel;
  logic                  alive;
  logic                  playing;
  logic                  died;

  modport master (
    output ena, frame_tick, flap_btn, restart, collide,
    input  bird_y, bird_vel, alive, playing, died
  );

  modport slave (
    input  ena, frame_tick, flap_btn, restart, collide,
    output bird_y, bird_vel, alive, playing, died
  );

endinterface

// File: rtl/flap_input_cond.sv
// Flap button conditioning: 2-FF synchronizer, optional debounce, rising-edge detect.
// Debounce is compiled in when FLAP_DEBOUNCE_EN is defined.
module flap_input_cond #(
`ifdef FLAP_DEBOUNCE_EN
  parameter int unsigned DEBOUNCE_CYCLES = 250000
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flap_btn_i,
  output logic flap_evt_o
);

  logic [1:0] sync_q;
  logic       level;
  logic       prev_q;

  // Synchronize the raw asynchronous button.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], flap_btn_i};
  end

`ifdef FLAP_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  // Level follows the synced input only after DEBOUNCE_CYCLES consecutive differing cycles.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  assign level = sync_q[1];
`endif

  // Previous level for rising-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= level;
  end

  assign flap_evt_o = level & ~prev_q;

endmodule

// File: rtl/bird_physics.sv
// Bird vertical motion engine: IDLE/PLAY/DEAD FSM plus per-frame gravity/flap integrator.
// Optional flap debounce is enabled by defining FLAP_DEBOUNCE_EN.
module bird_physics
  import flappy_pkg::*;
#(
  parameter int unsigned Y_START  = 240,
  parameter int unsigned Y_CEIL   = 0,
  parameter int unsigned Y_FLOOR  = 464,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned FLAP_VEL = 7,
  parameter int unsigned VMAX     = 8
`ifdef FLAP_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
`endif
) (
  input logic           clk,
  input logic           rst_n,
  bird_physics_if.slave bus
);

  game_state_t           state_q, state_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic signed [V_W-1:0] vel_q, vel_d;
  logic                  pend_q, pend_d;
  logic                  died_q, died_d;
  logic                  flap_evt;

  logic signed [V_W:0]   vel_inc;
  logic signed [V_W-1:0] vel_n;
  logic signed [Y_W+1:0] y_n;

  flap_input_cond #(
`ifdef FLAP_DEBOUNCE_EN
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
  ) u_flap_input_cond (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .flap_btn_i(bus.flap_btn),
    .flap_evt_o(flap_evt)
  );

  // Next-state, integrator and flap-pending logic.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    pend_d  = pend_q;
    died_d  = 1'b0;

    // A flap arriving on the tick cycle still applies to that tick.
    vel_inc = {vel_q[V_W-1], vel_q} + (V_W+1)'(GRAVITY);
    if (pend_q || flap_evt)                        vel_n = V_W'(0) - V_W'(FLAP_VEL);
    else if (vel_inc > $signed((V_W+1)'(VMAX)))    vel_n = V_W'(VMAX);
    else                                           vel_n = vel_inc[V_W-1:0];
    // Two extra bits keep the sum signed and free of wrap at both clamps.
    y_n = $signed({2'b00, y_q}) + $signed({{(Y_W+2-V_W){vel_n[V_W-1]}}, vel_n});

    if (bus.restart) begin
      state_d = IDLE;
      y_d     = Y_W'(Y_START);
      vel_d   = '0;
      pend_d  = 1'b0;
    end else if (bus.ena) begin
      unique case (state_q)
        IDLE: begin
          y_d   = Y_W'(Y_START);
          vel_d = '0;
          if (flap_evt) begin
            state_d = PLAY;
            pend_d  = 1'b1;
          end
        end
        PLAY: begin
          if (flap_evt) pend_d = 1'b1;
          if (bus.frame_tick) begin
            pend_d = 1'b0;
            if (bus.collide) begin
              state_d = DEAD;
              died_d  = 1'b1;
            end else if (y_n <= $signed((Y_W+2)'(Y_CEIL))) begin
              y_d   = Y_W'(Y_CEIL);
              vel_d = '0;
            end else if (y_n >= $signed((Y_W+2)'(Y_FLOOR))) begin
              y_d     = Y_W'(Y_FLOOR);
              vel_d   = '0;
              state_d = DEAD;
              died_d  = 1'b1;
            end else begin
              y_d   = y_n[Y_W-1:0];
              vel_d = vel_n;
            end
          end
        end
        DEAD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and integrator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= Y_W'(Y_START);
      vel_q   <= '0;
      pend_q  <= 1'b0;
      died_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      pend_q  <= pend_d;
      died_q  <= died_d;
    end
  end

  assign bus.bird_y   = y_q;
  assign bus.bird_vel = vel_q;
  assign bus.alive    = (state_q != DEAD);
  assign bus.playing  = (state_q == PLAY);
  assign bus.died     = died_q;

endmodule

// File: tb/tb_bird_physics.sv
// Directed self-checking bench for bird_physics; define FLAP_DEBOUNCE_EN for the debounce case.
module tb_bird_physics;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   died_cnt = 0;

  bird_physics_if bus ();

  bird_physics #(
`ifdef FLAP_DEBOUNCE_EN
    .DEBOUNCE_CYCLES(16)
`else
    .Y_START(240)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Count died pulses, sampled away from the active edge.
  always @(negedge clk) if (bus.died === 1'b1) died_cnt++;

`ifdef FLAP_DEBOUNCE_EN
  localparam int Hold = 24;
  localparam int Gap  = 24;
`else
  localparam int Hold = 4;
  localparam int Gap  = 2;
`endif

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
  endtask

  task automatic flap();
    @(negedge clk) bus.flap_btn = 1'b1;
    repeat (Hold) @(negedge clk);
    bus.flap_btn = 1'b0;
    repeat (Gap) @(negedge clk);
  endtask

  task automatic do_restart();
    @(negedge clk) bus.restart = 1'b1;
    @(negedge clk) bus.restart = 1'b0;
  endtask

  initial begin
    int n;
    int vmax_seen;
    int d0;

    bus.ena = 1'b1;
    bus.frame_tick = 1'b0;
    bus.flap_btn = 1'b0;
    bus.restart = 1'b0;
    bus.collide = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset values, first flap, first two ticks
    check("rst_y", bus.bird_y, 240);
    check("rst_vel", bus.bird_vel, 0);
    check("rst_alive", bus.alive, 1);
    check("rst_playing", bus.playing, 0);
    check("rst_died", bus.died, 0);
    repeat (6) @(negedge clk);
    flap();
    check("t1_playing", bus.playing, 1);
    tick();
    check("t1_vel1", bus.bird_vel, -7);
    check("t1_y1", bus.bird_y, 233);
    tick();
    check("t1_vel2", bus.bird_vel, -6);
    check("t1_y2", bus.bird_y, 227);

    // 2: free fall to the floor
    n = 0;
    vmax_seen = -100;
    d0 = died_cnt;
    for (int i = 0; i < 60; i++) begin
      if (!bus.alive) break;
      tick();
      n++;
      if (int'(bus.bird_vel) > vmax_seen) vmax_seen = int'(bus.bird_vel);
      if (!bus.alive) check("t2_died_with_dead", bus.died, 1);
    end
    @(negedge clk);
    check("t2_ticks_to_floor", n, 41);
    check("t2_vmax", vmax_seen, 8);
    check("t2_y", bus.bird_y, 464);
    check("t2_vel", bus.bird_vel, 0);
    check("t2_alive", bus.alive, 0);
    check("t2_died_once", died_cnt - d0, 1);

    // 3: repeated flaps pin the bird to the ceiling
    do_restart();
    for (int i = 0; i < 34; i++) begin
      flap();
      tick();
    end
    check("t3_y_pre", bus.bird_y, 2);
    check("t3_vel_pre", bus.bird_vel, -7);
    for (int i = 0; i < 2; i++) begin
      flap();
      tick();
    end
    check("t3_y_ceil", bus.bird_y, 0);
    check("t3_vel_ceil", bus.bird_vel, 0);
    check("t3_alive", bus.alive, 1);

    // 4: collide beats flap at y=300
    do_restart();
    flap();
    repeat (16) tick();
    check("t4_y248", bus.bird_y, 248);
    check("t4_vel8", bus.bird_vel, 8);
    repeat (10) tick();
    flap();
    tick();
    check("t4_y321", bus.bird_y, 321);
    repeat (6) tick();
    check("t4_y300", bus.bird_y, 300);
    check("t4_vel_m1", bus.bird_vel, -1);
    flap();
    @(negedge clk) begin bus.frame_tick = 1'b1; bus.collide = 1'b1; end
    @(negedge clk) begin bus.frame_tick = 1'b0; bus.collide = 1'b0; end
    check("t4_died", bus.died, 1);
    check("t4_alive", bus.alive, 0);
    check("t4_y_frozen", bus.bird_y, 300);
    check("t4_vel_frozen", bus.bird_vel, -1);
    flap();
    tick();
    check("t4_dead_playing", bus.playing, 0);
    check("t4_dead_y", bus.bird_y, 300);
    do_restart();
    check("t4_rst_y", bus.bird_y, 240);
    check("t4_rst_vel", bus.bird_vel, 0);
    check("t4_rst_alive", bus.alive, 1);
    check("t4_rst_playing", bus.playing, 0);

    // 5: flap coincident with tick, ena hold, mid-frame reset
    flap();
    tick();
    tick();
    check("t5_y227", bus.bird_y, 227);
`ifdef FLAP_DEBOUNCE_EN
    flap();
    tick();
`else
    @(negedge clk) bus.flap_btn = 1'b1;
    @(negedge clk);
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
`endif
    check("t5_coinc_vel", bus.bird_vel, -7);
    check("t5_coinc_y", bus.bird_y, 220);
    bus.flap_btn = 1'b0;
    repeat (Gap) @(negedge clk);
    bus.ena = 1'b0;
    tick();
    check("t5_ena_hold_y", bus.bird_y, 220);
    check("t5_ena_hold_vel", bus.bird_vel, -7);
    bus.ena = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_arst_y", bus.bird_y, 240);
    check("t5_arst_vel", bus.bird_vel, 0);
    check("t5_arst_playing", bus.playing, 0);
    check("t5_arst_alive", bus.alive, 1);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("t5_idle_tick_y", bus.bird_y, 240);
    check("t5_idle_tick_playing", bus.playing, 0);

`ifdef FLAP_DEBOUNCE_EN
    // 6: debounce rejects a short glitch and passes a long press once
    @(negedge clk) bus.flap_btn = 1'b1;
    repeat (10) @(negedge clk);
    bus.flap_btn = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_glitch_playing", bus.playing, 0);
    @(negedge clk) bus.flap_btn = 1'b1;
    repeat (20) @(negedge clk);
    bus.flap_btn = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_press_playing", bus.playing, 1);
    tick();
    check("t6_vel1", bus.bird_vel, -7);
    tick();
    check("t6_vel2", bus.bird_vel, -6);
    check("t6_y2", bus.bird_y, 227);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
